sqrt_stream_sequencer: RTL and testbench

//  Upstream/downstream sequencer for the sequential sqrt core. Accepts 32-bit operands on a

---
 rtl/sqrt_stream_sequencer.sv | 118 +++++++++++
 tb/tb_sqrt_stream_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_stream_sequencer.sv
// sqrt_stream_sequencer: valid/ready front end that launches one sqrt per operand and returns root, remainder and exact flag
module sqrt_stream_sequencer #(
    parameter int START_TIMEOUT = 8,
    parameter int RUN_TIMEOUT   = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    output logic        sqrt_run,
    output logic [31:0] sqrt_xin,
    input  logic        sqrt_busy,
    input  logic [15:0] sqrt_root,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_root,
    output logic [16:0] out_rem,
    output logic        out_exact,
    output logic        out_err
);
    localparam int WW = $clog2(RUN_TIMEOUT > START_TIMEOUT ? RUN_TIMEOUT : START_TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO, CAPT, ERR, OUT} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [31:0]   xin_q, xin_d;
    logic [15:0]   root_q, root_d;
    logic [16:0]   rem_q, rem_d;
    logic          exact_q, exact_d;
    logic          err_q, err_d;
    logic [16:0]   rem_w;

    // Only the low 17 bits survive: for a true floor root the remainder never exceeds 2*root
    assign rem_w = 17'(xin_q - {16'd0, sqrt_root} * {16'd0, sqrt_root});

    assign in_ready  = state_q == IDLE;
    assign sqrt_run  = state_q == LAUNCH;
    assign out_valid = state_q == OUT;
    assign sqrt_xin  = xin_q;
    assign out_root  = root_q;
    assign out_rem   = rem_q;
    assign out_exact = exact_q;
    assign out_err   = err_q;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wd_q    <= '0;
            xin_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            xin_q   <= xin_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            exact_q <= exact_d;
            err_q   <= err_d;
        end
    end

    // Next state, watchdog and result capture; busy is only sampled in the two wait states
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        xin_d   = xin_q;
        root_d  = root_q;
        rem_d   = rem_q;
        exact_d = exact_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xin_d   = in_x;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (sqrt_busy) begin
                    wd_d    = '0;
                    state_d = WAIT_LO;
                end else if (wd_q == WW'(START_TIMEOUT - 1)) state_d = ERR;
                else wd_d = wd_q + WW'(1);
            end
            WAIT_LO: begin
                if (!sqrt_busy) state_d = CAPT;
                else if (wd_q == WW'(RUN_TIMEOUT - 1)) state_d = ERR;
                else wd_d = wd_q + WW'(1);
            end
            CAPT: begin
                root_d  = sqrt_root;
                rem_d   = rem_w;
                exact_d = rem_w == 17'd0;
                err_d   = 1'b0;
                state_d = OUT;
            end
            ERR: begin
                root_d  = '0;
                rem_d   = '0;
                exact_d = 1'b0;
                err_d   = 1'b1;
                state_d = OUT;
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sqrt_stream_sequencer.sv
// tb_sqrt_stream_sequencer: table-driven and directed checks of the sqrt stream sequencer against a behavioural core
module tb_sqrt_stream_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic        sqrt_run;
    logic [31:0] sqrt_xin;
    logic        sqrt_busy;
    logic [15:0] sqrt_root;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_root;
    logic [16:0] out_rem;
    logic        out_exact;
    logic        out_err;

    int n_vec = 0;
    int n_bad = 0;

    int hi_delay   = 1;
    int busy_len   = 16;
    bit never_busy = 1'b0;
    int phase;
    int cnt;

    sqrt_stream_sequencer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .sqrt_run(sqrt_run), .sqrt_xin(sqrt_xin), .sqrt_busy(sqrt_busy), .sqrt_root(sqrt_root),
        .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_rem(out_rem),
        .out_exact(out_exact), .out_err(out_err)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] isqrt(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | 16'(1 << b);
            if ({16'd0, t} * {16'd0, t} <= v) r = t;
        end
        return r;
    endfunction

    // Behavioural core: busy rises hi_delay cycles after run, stays up busy_len cycles
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sqrt_busy <= 1'b0;
            sqrt_root <= '0;
            phase     <= 0;
            cnt       <= 0;
        end else if (phase == 0) begin
            if (sqrt_run && !never_busy) begin
                phase <= 1;
                cnt   <= hi_delay;
            end
        end else if (phase == 1) begin
            if (cnt <= 1) begin
                sqrt_busy <= 1'b1;
                sqrt_root <= isqrt(sqrt_xin);
                phase     <= 2;
                cnt       <= busy_len;
            end else cnt <= cnt - 1;
        end else begin
            if (cnt <= 1) begin
                sqrt_busy <= 1'b0;
                phase     <= 0;
            end else cnt <= cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] x, input logic [15:0] er, input logic [16:0] erem,
                         input logic ee, input logic eerr, input int hold, input int exp_lat);
        int k;
        int runs;
        logic xbad;
        k = 0;
        while ((sqrt_busy || !in_ready) && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("idle_wait", 32'(k < 200), 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        @(negedge clock);
        in_valid = 1'b0;
        in_x     = $urandom;
        k = 1;
        runs = 0;
        xbad = 1'b0;
        while (!out_valid && k < 200) begin
            runs += int'(sqrt_run);
            xbad |= sqrt_xin != x;
            @(negedge clock);
            k++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        if (exp_lat > 0) chk("latency", k, exp_lat);
        chk("root", 32'(out_root), 32'(er));
        chk("rem", 32'(out_rem), 32'(erem));
        chk("exact", 32'(out_exact), 32'(ee));
        chk("err", 32'(out_err), 32'(eerr));
        chk("run_pulses", runs, 1);
        chk("xin_stable", 32'(xbad), 32'd0);
        chk("in_ready_out", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_root", 32'(out_root), 32'(er));
            chk("hold_rem", 32'(out_rem), 32'(erem));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_run", 32'(sqrt_run), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("consumed", 32'(out_valid), 32'd0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [15:0] r;
        logic [16:0] rem;
        logic        ex;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{32'd144,        16'd12,    17'd0,      1'b1};
        tbl[1]  = '{32'd17,         16'd4,     17'd1,      1'b0};
        tbl[2]  = '{32'hFFFFFFFF,   16'd65535, 17'd131070, 1'b0};
        tbl[3]  = '{32'd0,          16'd0,     17'd0,      1'b1};
        tbl[4]  = '{32'd81,         16'd9,     17'd0,      1'b1};
        tbl[5]  = '{32'd2,          16'd1,     17'd1,      1'b0};
        tbl[6]  = '{32'd1000000,    16'd1000,  17'd0,      1'b1};
        tbl[7]  = '{32'd99,         16'd9,     17'd18,     1'b0};
        tbl[8]  = '{32'd65536,      16'd256,   17'd0,      1'b1};
        tbl[9]  = '{32'hFFFE0001,   16'd65535, 17'd0,      1'b1};
        tbl[10] = '{32'hFFFE0000,   16'd65534, 17'd131068, 1'b0};

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_run", 32'(sqrt_run), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_xin", sqrt_xin, 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        foreach (tbl[i]) do_op(tbl[i].x, tbl[i].r, tbl[i].rem, tbl[i].ex, 1'b0, 0, 0);

        // Core never answers: start watchdog expires after 8 cycles in WAIT_HI
        never_busy = 1'b1;
        do_op(32'd144, 16'd0, 17'd0, 1'b0, 1'b1, 0, 11);
        never_busy = 1'b0;

        // Core stays busy too long: run watchdog expires after 64 cycles in WAIT_LO
        busy_len = 100;
        do_op(32'd50, 16'd0, 17'd0, 1'b0, 1'b1, 0, 69);
        busy_len = 16;

        // Slower start, then a result held under 5 cycles of backpressure
        hi_delay = 3;
        do_op(32'd144, 16'd12, 17'd0, 1'b1, 1'b0, 5, 0);
        hi_delay = 1;

        // Reset while the core is busy
        busy_len = 40;
        in_valid = 1'b1;
        in_x     = 32'd144;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (6) @(negedge clock);
        chk("pre_rst_busy", 32'(sqrt_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_run", 32'(sqrt_run), 32'd0);
        chk("mid_rst_xin", sqrt_xin, 32'd0);
        chk("mid_rst_root", 32'(out_root), 32'd0);
        chk("mid_rst_rem", 32'(out_rem), 32'd0);
        chk("mid_rst_exact", 32'(out_exact), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        busy_len = 16;
        @(negedge clock);
        do_op(32'd81, 16'd9, 17'd0, 1'b1, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
